// File: rtl/sipo_deframer.sv
// Dual-rail serial-to-parallel deframer: reassembles LSB-first 2-bit symbols into
// DATAWIDTH-bit words behind a one-word holding register with valid/ready output.
module sipo_deframer #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic [1:0]           din_data,
  input  logic                 din_last,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [DATAWIDTH-1:0] dout_data,
  input  logic                 clr_err,
  output logic                 code_err,
  output logic                 frame_err
);

  localparam int CNT_W = $clog2(DATAWIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATAWIDTH - 1);

  typedef enum logic [1:0] {
    COLLECT,
    HOLD,
    STALL
  } state_e;

  // Only 2'b01 is a one; every other code, legal or not, decodes as zero.
  function automatic logic decode_bit(input logic [1:0] code);
    return code == 2'b01;
  endfunction

  function automatic logic code_bad(input logic [1:0] code);
    return code[0] == code[1];
  endfunction

  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 hold_valid_q, hold_valid_d;
  logic [DATAWIDTH-1:0] hold_q, hold_d;
  logic [DATAWIDTH-1:0] shift_q, shift_d;
  logic                 code_err_q, code_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 accept;
  logic                 at_last;
  state_e               state;

  // State is a pure function of the counter, hold occupancy and consumer readiness,
  // so a drain and a final-bit acceptance can share the same cycle.
  always_comb begin
    state = COLLECT;
    if (hold_valid_q) begin
      state = (bit_cnt_q == LAST_IDX && !dout_ready) ? STALL : HOLD;
    end
  end

  assign din_ready  = (state != STALL);
  assign dout_valid = hold_valid_q;
  assign dout_data  = hold_q;
  assign code_err   = code_err_q;
  assign frame_err  = frame_err_q;

  always_comb begin
    accept       = din_valid && din_ready;
    at_last      = (bit_cnt_q == LAST_IDX);
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    frame_err_d  = 1'b0;
    code_err_d   = clr_err ? 1'b0 : code_err_q;

    if (hold_valid_q && dout_ready) begin
      hold_valid_d = 1'b0;
    end

    if (accept) begin
      shift_d[bit_cnt_q] = decode_bit(din_data);
      // A fresh bad code overrides a simultaneous clear.
      if (code_bad(din_data)) begin
        code_err_d = 1'b1;
      end
      if (at_last || din_last) begin
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
      if (at_last && din_last) begin
        hold_d       = shift_d;
        hold_valid_d = 1'b1;
      end else if (at_last || din_last) begin
        frame_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q    <= '0;
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
      code_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
      code_err_q   <= code_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Every shift position is rewritten before a word completes, so no reset is needed.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_sipo_deframer.sv
// Scoreboard bench for sipo_deframer: directed words pushed as expectations,
// an independent monitor pops and compares on every output handshake.
module tb_sipo_deframer;

  logic       clk;
  logic       rst;
  logic       din_valid;
  logic       din_ready;
  logic [1:0] din_data;
  logic       din_last;
  logic       dout_valid;
  logic       dout_ready;
  logic [7:0] dout_data;
  logic       clr_err;
  logic       code_err;
  logic       frame_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hs_prev = 0;
  int hs_last = 0;
  int fe_cnt = 0;
  int stall_cnt = 0;
  logic fe_prev = 1'b0;
  logic held_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;
  logic [7:0] exp_q[$];

  sipo_deframer #(.DATAWIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data), .din_last(din_last),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .clr_err(clr_err), .code_err(code_err), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: output handshakes, frame_err pulses, stalls and hold stability.
  always @(negedge clk) begin
    if (!rst) begin
      if (held_prev) check("hold_stable", {24'h0, dout_data}, {24'h0, data_prev});
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %0h expected none", dout_data);
        end else begin
          check("word", {24'h0, dout_data}, {24'h0, exp_q.pop_front()});
        end
        hs_prev = hs_last;
        hs_last = cyc;
      end
      if (frame_err) begin
        fe_cnt++;
        if (fe_prev) begin
          tests++;
          fails++;
          $display("FAIL frame_err_width: got 2+ cycles expected 1");
        end
      end
      if (din_valid && !din_ready) stall_cnt++;
      fe_prev   = frame_err;
      held_prev = dout_valid && !dout_ready;
      data_prev = dout_data;
    end else begin
      fe_prev   = 1'b0;
      held_prev = 1'b0;
    end
  end

  task automatic send_bit(input logic [1:0] c, input logic l);
    int n;
    din_valid = 1'b1;
    din_data  = c;
    din_last  = l;
    n = 0;
    @(negedge clk);
    while (!din_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!din_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got din_ready=0 expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din_last  = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input int nbits, input int last_idx,
                           input int bad_idx, input logic [1:0] bad_code);
    logic [1:0] c;
    for (int i = 0; i < nbits; i++) begin
      c = w[i] ? 2'b01 : 2'b10;
      if (i == bad_idx) c = bad_code;
      send_bit(c, i == last_idx);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int stall0;
    int fe0;
    logic [7:0] w80;
    rst = 1'b1; din_valid = 1'b0; din_data = 2'b00; din_last = 1'b0;
    dout_ready = 1'b1; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_dout_data", dout_data, 0);
    check("rst_din_ready", din_ready, 1);
    check("rst_code_err", code_err, 0);
    check("rst_frame_err", frame_err, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single word 0xA5
    exp_q.push_back(8'hA5);
    send_word(8'hA5, 8, 7, -1, 2'b00);
    check("a5_latency_valid", dout_valid, 1);
    check("a5_latency_data", dout_data, 8'hA5);
    check("a5_code_err", code_err, 0);
    @(posedge clk); #1;

    // Back-to-back 0x3C, 0xFF
    stall0 = stall_cnt;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hFF);
    send_word(8'h3C, 8, 7, -1, 2'b00);
    send_word(8'hFF, 8, 7, -1, 2'b00);
    @(negedge clk); #1;
    check("b2b_spacing", hs_last - hs_prev, 8);
    check("b2b_no_stall", stall_cnt - stall0, 0);

    // Backpressure
    @(posedge clk); #1 dout_ready = 1'b0;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_word(8'h11, 8, 7, -1, 2'b00);
    fork
      send_word(8'h22, 8, 7, -1, 2'b00);
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!(din_valid && !din_ready) && n < 200) begin
          @(negedge clk);
          n++;
        end
        check("bp_stall_seen", n < 200, 1);
        check("bp_stall_on_bit7", din_last, 1);
        check("bp_hold_data", dout_data, 8'h11);
        repeat (3) @(negedge clk);
        check("bp_still_stalled", din_ready, 0);
        @(posedge clk); #1 dout_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_comb", din_ready, 1);
      end
    join
    @(negedge clk); #1;
    check("bp_queue_drained", exp_q.size(), 0);

    // Framing: early last, then a good word, then missing last
    @(posedge clk); #1;
    fe0 = fe_cnt;
    send_word(8'h0F, 4, 3, -1, 2'b00);
    check("early_frame_err", frame_err, 1);
    @(posedge clk); #1;
    check("early_frame_err_low", frame_err, 0);
    check("early_fe_count", fe_cnt, fe0 + 1);
    check("early_no_valid", dout_valid, 0);
    exp_q.push_back(8'h5A);
    send_word(8'h5A, 8, 7, -1, 2'b00);
    send_word(8'h77, 8, -1, -1, 2'b00);
    check("missing_frame_err", frame_err, 1);
    @(posedge clk); #1;
    check("missing_frame_err_low", frame_err, 0);
    check("missing_no_valid", dout_valid, 0);
    check("framing_fe_count", fe_cnt, fe0 + 2);

    // Code error: bit 2 coded 11
    exp_q.push_back(8'hFB);
    send_word(8'hFF, 8, 7, 2, 2'b11);
    check("code_err_set", code_err, 1);
    repeat (3) @(posedge clk); #1;
    check("code_err_sticky", code_err, 1);
    clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    check("code_err_cleared", code_err, 0);
    w80 = 8'h80;
    exp_q.push_back(w80);
    clr_err = 1'b1;
    send_bit(2'b00, 1'b0);
    clr_err = 1'b0;
    check("code_err_set_wins", code_err, 1);
    for (int i = 1; i < 8; i++) send_bit(w80[i] ? 2'b01 : 2'b10, i == 7);
    @(negedge clk); #1;
    check("code_queue_drained", exp_q.size(), 0);

    // Reset mid-frame with a word held
    @(posedge clk); #1 dout_ready = 1'b0;
    send_word(8'h42, 8, 7, -1, 2'b00);
    send_word(8'h03, 4, -1, -1, 2'b00);
    #2 rst = 1'b1;
    #1;
    check("arst_dout_valid", dout_valid, 0);
    check("arst_din_ready", din_ready, 1);
    check("arst_dout_data", dout_data, 0);
    check("arst_code_err", code_err, 0);
    #2 rst = 1'b0;
    dout_ready = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(8'h81);
    send_word(8'h81, 8, 7, -1, 2'b00);
    @(negedge clk); #1;
    check("final_queue_drained", exp_q.size(), 0);
    check("final_fe_count", fe_cnt, fe0 + 2);
    check("final_code_err", code_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
